// File: rtl/esp32_spi_regs_pkg.sv
// ---------------------------------------------------------------------------
// esp32_spi_pkg
// Shared definitions for the ESP32 register-mapped SPI slave:
//   - frame state encodings
//   - register addresses and command-byte layout
//   - register read mux helper
// ---------------------------------------------------------------------------
package esp32_spi_pkg;

  // Frame states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Register map
  localparam logic [6:0] A_BTN = 7'h00;
  localparam logic [6:0] A_LED = 7'h01;
  localparam logic [6:0] A_ID  = 7'h02;

  // Command byte: bit 7 = rw (1 = read), bits 6:0 = address
  localparam int RW_BIT = 7;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
  } spi_cmd_t;

  function automatic logic [7:0] reg_read(input logic [6:0] addr,
                                          input logic [7:0] btn_snap,
                                          input logic [7:0] led,
                                          input logic [7:0] id);
    logic [7:0] v;
    v = 8'h00;
    case (addr)
      A_BTN:   v = btn_snap;
      A_LED:   v = led;
      A_ID:    v = id;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/esp32_spi_regs_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// N-stage synchroniser for one asynchronous bit, followed by one further
// registered copy used for edge detection. Rise/fall pulses are registered,
// so a pin edge becomes a one-clk pulse C_stages+1 clocks later.
//
// Ports:
//   clk     in   system clock
//   rstn    in   synchronous reset, active-low
//   i_d     in   asynchronous input
//   o_rise  out  one-clk pulse on a synchronised 0->1 transition
//   o_fall  out  one-clk pulse on a synchronised 1->0 transition
//
// C_init is the idle level the chain is preset to during reset, so that
// releasing reset with the pin at its idle level produces no edge.
// ---------------------------------------------------------------------------
module sync_edge #(
  parameter int   C_stages = 2,
  parameter logic C_init   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [C_stages-1:0] r_chain;
  logic                r_prev;
  logic                r_rise;
  logic                r_fall;
  logic                w_sync;

  assign w_sync = r_chain[C_stages-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_chain <= {C_stages{C_init}};
      r_prev  <= C_init;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_chain <= {r_chain[C_stages-2:0], i_d};
      r_prev  <= w_sync;
      r_rise  <= w_sync & ~r_prev;
      r_fall  <= ~w_sync & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/esp32_spi_regs.sv
// ---------------------------------------------------------------------------
// esp32_spi_regs
// Register-mapped SPI slave (mode 0) for the ESP32 bus. SCLK/CSn/MOSI are
// oversampled on clk_25MHz; SCLK high and low phases must each last >= 4 clk.
//
// Ports:
//   clk_25MHz  in   system clock
//   rstn       in   synchronous reset, active-low
//   spi_sclk   in   async SCLK
//   spi_csn    in   async chip select, active-low
//   spi_mosi   in   async MOSI
//   miso       out  MISO data (top level owns the tri-state)
//   miso_oe    out  MISO drive enable
//   btn        in   raw buttons, async
//   led        out  LED register
//   led_wr     out  one-clk pulse on each LED register write
//   busy       out  high while a frame is active
//
// Register map: 0x00 btn_snap (RO), 0x01 led (RW), 0x02 C_id (RO),
// everything else reads 0x00 and ignores writes.
//
// Build option: ESP32_SPI_AUTOINC_EN -- after each data byte the address
// increments (7-bit wrap) and another data byte follows; otherwise the
// frame ends in DONE after one data byte.
//
// state | meaning
// IDLE  | no frame; waiting for an armed csn fall
// CMD   | shifting the command byte in, button snapshot out
// DATA  | shifting the data byte (write data in / register value out)
// DONE  | frame complete; SCLK ignored, miso held 0 until csn rises
// ---------------------------------------------------------------------------
module esp32_spi_regs
  import esp32_spi_pkg::*;
#(
  parameter int         C_sync_stages = 2,
  parameter logic [7:0] C_id          = 8'hE5,
  parameter int         C_btn_bits    = 7
) (
  input  logic                  clk_25MHz,
  input  logic                  rstn,
  input  logic                  spi_sclk,
  input  logic                  spi_csn,
  input  logic                  spi_mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [C_btn_bits-1:0] btn,
  output logic [7:0]            led,
  output logic                  led_wr,
  output logic                  busy
);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_csn_rise;
  logic w_csn_fall;

  sync_edge #(.C_stages(C_sync_stages), .C_init(1'b0)) u_sync_sclk (
    .clk    (clk_25MHz),
    .rstn   (rstn),
    .i_d    (spi_sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  sync_edge #(.C_stages(C_sync_stages), .C_init(1'b1)) u_sync_csn (
    .clk    (clk_25MHz),
    .rstn   (rstn),
    .i_d    (spi_csn),
    .o_rise (w_csn_rise),
    .o_fall (w_csn_fall)
  );

  // Plain synchronisers for MOSI and buttons
  logic [C_sync_stages-1:0] r_mosi_sync;
  logic [C_btn_bits-1:0]    r_btn_sync [C_sync_stages];

  always_ff @(posedge clk_25MHz) begin
    if (!rstn) begin
      r_mosi_sync <= '0;
      for (int i = 0; i < C_sync_stages; i++) r_btn_sync[i] <= '0;
    end else begin
      r_mosi_sync   <= {r_mosi_sync[C_sync_stages-2:0], spi_mosi};
      r_btn_sync[0] <= btn;
      for (int i = 1; i < C_sync_stages; i++) r_btn_sync[i] <= r_btn_sync[i-1];
    end
  end

  logic       w_mosi;
  logic [7:0] w_btn_ext;

  assign w_mosi    = r_mosi_sync[C_sync_stages-1];
  assign w_btn_ext = 8'(r_btn_sync[C_sync_stages-1]);

  // Frame state
  logic [1:0] r_state;
  logic [2:0] r_bitcnt;
  logic [7:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic [7:0] r_btn_snap;
  logic [7:0] r_led;
  logic       r_led_wr;
  logic       r_miso;
  logic       r_miso_oe;
  spi_cmd_t   r_cmd;

  // Post-reset arming: the csn chain is preset high, so a pin already low at
  // reset release shows up as a fall pulse inside the settle window. That
  // fall must not open a frame; only a genuine high->low after release does.
  logic [3:0] r_settle;
  logic       r_hold_low;
  logic       r_armed;

  logic [7:0] w_rx_next;
  logic [7:0] w_rd_data;

  assign w_rx_next = {r_rx_sh[6:0], w_mosi};
  assign w_rd_data = reg_read(w_rx_next[6:0], r_btn_snap, r_led, C_id);

`ifdef ESP32_SPI_AUTOINC_EN
  logic [6:0] w_next_addr;
  logic [7:0] w_inc_data;

  assign w_next_addr = r_cmd.addr + 7'd1;
  assign w_inc_data  = reg_read(w_next_addr, r_btn_snap, r_led, C_id);
`endif

  always_ff @(posedge clk_25MHz) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 3'd0;
      r_rx_sh    <= 8'h00;
      r_tx_sh    <= 8'h00;
      r_btn_snap <= 8'h00;
      r_led      <= 8'h00;
      r_led_wr   <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_cmd      <= '0;
      r_settle   <= 4'(C_sync_stages + 2);
      r_hold_low <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_led_wr <= 1'b0;

      if (r_settle != 4'd0) begin
        r_settle <= r_settle - 4'd1;
        if (w_csn_fall) r_hold_low <= 1'b1;
      end else if (!r_hold_low) begin
        r_armed <= 1'b1;
      end
      if (w_csn_rise) begin
        r_hold_low <= 1'b0;
        r_armed    <= 1'b1;
      end

      // csn rise has priority over any sclk edge in the same clk
      if (w_csn_rise) begin
        r_state   <= ST_IDLE;
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
        r_bitcnt  <= 3'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_csn_fall && r_armed) begin
              r_btn_snap <= w_btn_ext;
              r_state    <= ST_CMD;
              r_bitcnt   <= 3'd0;
              r_rx_sh    <= 8'h00;
              r_miso_oe  <= 1'b1;
              r_miso     <= w_btn_ext[7];
              // tx_sh holds the bits still to go out after the current one
              r_tx_sh    <= {w_btn_ext[6:0], 1'b0};
            end
          end

          ST_CMD, ST_DATA: begin
            if (w_sclk_rise) begin
              r_rx_sh  <= w_rx_next;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (r_state == ST_CMD) begin
                  r_cmd.rw   <= w_rx_next[RW_BIT];
                  r_cmd.addr <= w_rx_next[6:0];
                  r_tx_sh    <= w_rx_next[RW_BIT] ? w_rd_data : 8'h00;
                  r_state    <= ST_DATA;
                end else begin
                  if (!r_cmd.rw && (r_cmd.addr == A_LED)) begin
                    r_led    <= w_rx_next;
                    r_led_wr <= 1'b1;
                  end
`ifdef ESP32_SPI_AUTOINC_EN
                  r_cmd.addr <= w_next_addr;
                  r_tx_sh    <= r_cmd.rw ? w_inc_data : 8'h00;
`else
                  r_state <= ST_DONE;
                  r_tx_sh <= 8'h00;
                  r_miso  <= 1'b0;
`endif
                end
              end
            end else if (w_sclk_fall) begin
              r_miso  <= r_tx_sh[7];
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
          end

          default: begin
            r_miso <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso    = r_miso;
  assign miso_oe = r_miso_oe;
  assign led     = r_led;
  assign led_wr  = r_led_wr;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_esp32_spi_regs.sv
// ---------------------------------------------------------------------------
// tb_esp32_spi_regs
// Directed SPI frames against esp32_spi_regs with a register-level model of
// the slave (snapshot, LED register, ID, optional address auto-increment).
// ---------------------------------------------------------------------------
module tb_esp32_spi_regs;

  localparam int H = 8;  // SCLK half period in clk

  logic       clk_25MHz;
  logic       rstn;
  logic       spi_sclk;
  logic       spi_csn;
  logic       spi_mosi;
  logic       miso;
  logic       miso_oe;
  logic [6:0] btn;
  logic [7:0] led;
  logic       led_wr;
  logic       busy;

  esp32_spi_regs dut (
    .clk_25MHz (clk_25MHz),
    .rstn      (rstn),
    .spi_sclk  (spi_sclk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .btn       (btn),
    .led       (led),
    .led_wr    (led_wr),
    .busy      (busy)
  );

  initial clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef ESP32_SPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // Model state
  logic [7:0] model_led;
  logic [7:0] model_snap;
  logic       exp_active;

  function automatic logic [7:0] model_reg(input logic [6:0] a);
    if (a == 7'h00) return model_snap;
    if (a == 7'h01) return model_led;
    if (a == 7'h02) return 8'hE5;
    return 8'h00;
  endfunction

  // Per-cycle monitor
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_rise_cyc = 0;
  int   last_pulse_cyc = 0;
  int   quiet = 0;
  logic prev_wr = 1'b0;
  logic last_csn = 1'b1;
  logic last_rstn = 1'b0;
  logic last_sclk = 1'b0;

  always @(negedge clk_25MHz) begin
    cyc++;
    if (spi_sclk && !last_sclk) last_rise_cyc = cyc;
    last_sclk = spi_sclk;
    if (led_wr === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      check("led_wr_width", 32'(prev_wr), 32'd0);
    end
    prev_wr = led_wr;
    if (spi_csn != last_csn || rstn != last_rstn) quiet = 0;
    else if (quiet < 1000) quiet++;
    last_csn  = spi_csn;
    last_rstn = rstn;
    if (quiet >= 6 && rstn) begin
      check("miso_oe", 32'(miso_oe), 32'(exp_active));
      check("busy", 32'(busy), 32'(exp_active));
      if (spi_csn) begin
        check("led_idle", 32'(led), 32'(model_led));
        check("miso_idle", 32'(miso), 32'd0);
      end
    end
  end

  logic [7:0] tx_buf [4];
  logic [7:0] rx_buf [4];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_25MHz);
      #5;
    end
  endtask

  // One SPI frame, master side, with model update and comparison afterwards.
  task automatic spi_xfer(input int nbytes, input int nbits, input int rst_bit,
                          input logic chg_btn, input logic [6:0] new_btn);
    logic [7:0] cmd;
    logic [6:0] a;
    logic       live;
    logic       frame_ok;
    int         p0;
    int         exp_pulses;
    frame_ok   = 1'b1;
    exp_pulses = 0;
    p0         = pulse_cnt;
    model_snap = {1'b0, btn};
    for (int k = 0; k < 4; k++) rx_buf[k] = 8'h00;
    spi_csn    = 1'b0;
    exp_active = 1'b1;
    tick(H);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_bit) begin
        rstn       = 1'b0;
        exp_active = 1'b0;
        frame_ok   = 1'b0;
        model_led  = 8'h00;
        tick(2);
        rstn = 1'b1;
      end
      if (chg_btn && b == 4) btn = new_btn;
      spi_mosi = tx_buf[b/8][7-(b%8)];
      tick(H);
      spi_sclk = 1'b1;
      rx_buf[b/8][7-(b%8)] = miso;
      tick(H);
      spi_sclk = 1'b0;
    end
    tick(H);
    spi_csn    = 1'b1;
    exp_active = 1'b0;

    cmd = tx_buf[0];
    if (frame_ok && nbits == nbytes * 8) begin
      check("cmd_phase_snap", 32'(rx_buf[0]), 32'(model_snap));
      for (int k = 1; k < nbytes; k++) begin
        a    = AUTOINC ? 7'(cmd[6:0] + 7'(k - 1)) : cmd[6:0];
        live = AUTOINC || (k == 1);
        if (cmd[7]) begin
          check("read_byte", 32'(rx_buf[k]), live ? 32'(model_reg(a)) : 32'd0);
        end else if (live && a == 7'h01) begin
          model_led = tx_buf[k];
          exp_pulses++;
        end
      end
    end
    tick(2 * H);
    check("led_wr_count", 32'(pulse_cnt - p0), 32'(exp_pulses));
  endtask

  int d;

  initial begin
    rstn       = 1'b0;
    spi_sclk   = 1'b0;
    spi_csn    = 1'b1;
    spi_mosi   = 1'b0;
    btn        = 7'h00;
    model_led  = 8'h00;
    model_snap = 8'h00;
    exp_active = 1'b0;
    for (int k = 0; k < 4; k++) tx_buf[k] = 8'h00;

    // Reset state
    tick(4);
    check("rst_led", 32'(led), 32'h00);
    check("rst_led_wr", 32'(led_wr), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    tick(12);

    // Read ID
    tx_buf[0] = 8'h82; tx_buf[1] = 8'h00;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);
    check("id_literal", 32'(rx_buf[1]), 32'hE5);

    // Button snapshot; btn changes mid-frame must not leak into the output
    btn = 7'h55;
    tick(8);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
    spi_xfer(2, 16, -1, 1'b1, 7'h2A);
    check("snap_cmd_literal", 32'(rx_buf[0]), 32'h55);
    check("snap_data_literal", 32'(rx_buf[1]), 32'h55);
    btn = 7'h55;
    tick(8);

    // LED write, pulse latency, read-back
    tx_buf[0] = 8'h01; tx_buf[1] = 8'hA3;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);
    check("led_literal", 32'(led), 32'hA3);
    d = last_pulse_cyc - last_rise_cyc;
    checks++;
    if (!(d >= 3 && d <= 4)) begin
      errors++;
      $display("FAIL led_wr_latency: got %0d clk, expected 3..4", d);
    end
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);
    check("led_readback_literal", 32'(rx_buf[1]), 32'hA3);

    // Aborted write after 11 bits, then a full frame
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h3C;
    spi_xfer(2, 11, -1, 1'b0, 7'h00);
    check("abort_led", 32'(led), 32'hA3);
    check("abort_busy", 32'(busy), 32'd0);
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);

    // Writes to RO and unmapped addresses
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h77;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h11;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h00;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);

    // Multi-byte read from 0x00
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    spi_xfer(4, 32, -1, 1'b0, 7'h00);
    check("burst_b1_literal", 32'(rx_buf[1]), 32'h55);
    check("burst_b2_literal", 32'(rx_buf[2]), AUTOINC ? 32'hA3 : 32'h00);
    check("burst_b3_literal", 32'(rx_buf[3]), AUTOINC ? 32'hE5 : 32'h00);

    // Reset mid-DATA of a write; rest of that frame must be ignored
    tx_buf[0] = 8'h01; tx_buf[1] = 8'hFF;
    spi_xfer(2, 16, 12, 1'b0, 7'h00);
    check("mid_rst_led", 32'(led), 32'h00);
    check("mid_rst_oe", 32'(miso_oe), 32'd0);
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
    spi_xfer(2, 16, -1, 1'b0, 7'h00);
    check("post_rst_read_literal", 32'(rx_buf[1]), 32'h00);
    check("post_rst_snap_literal", 32'(rx_buf[0]), 32'h55);

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
